ro_puf_ctrl: RTL
================

RO_PUF_CTRL -- requirements
Module: ro_puf_ctrl

Interface
REQ-001 Parameter NUM_BITS, default 8, response bits generated per challenge (1..32).
REQ-002 Parameter CLR_CYCLES, default 2, cycles the counter clear is held before each race (>=1).
REQ-003 Parameter TIMEOUT, default 1024, maximum race cycles before a bit is declared a tie (2..65535).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request a response generation; sampled only in IDLE.
REQ-007 challenge  input  8  LFSR seed, sampled in the cycle start is accepted.
REQ-008 cnt1_max  input  1  counter on sel0 path reached max value (clk-synchronous level).
REQ-009 cnt2_max  input  1  counter on sel1 path reached max value (clk-synchronous level).
REQ-010 sel0  output  4  mux select for oscillator A.
REQ-011 sel1  output  4  mux select for oscillator B; never equal to sel0 while ro_en=1.
REQ-012 ro_en  output  1  oscillator enable.
REQ-013 cnt_clr_n  output  1  active-low counter clear to the datapath.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 resp_valid  output  1  one-cycle pulse when response is complete.
REQ-016 response  output  NUM_BITS  collected response, bit i from race i.
REQ-017 tie_flags  output  NUM_BITS  bit i set when race i was a tie or timeout.

Function
REQ-018 States IDLE, CLEAR, RACE, NEXT, DONE; encoding free.
REQ-019 IDLE: start=1 -> load LFSR with challenge (8'h00 replaced by 8'h01), bit index=0, response=0, tie_flags=0, go CLEAR.
REQ-020 start while busy=1 shall be ignored with no effect.
REQ-021 sel0=lfsr[3:0]; sel1=lfsr[7:4], or lfsr[7:4]^4'h8 when lfsr[7:4]==lfsr[3:0]; registered, stable for the whole bit.
REQ-022 CLEAR: cnt_clr_n=0, ro_en=0 for exactly CLR_CYCLES cycles, then RACE.
REQ-023 RACE: cnt_clr_n=1, ro_en=1; 16-bit race timer starts at 0 in first RACE cycle, increments each cycle.
REQ-024 RACE decision per cycle: cnt1_max=1,cnt2_max=0 -> bit=0; cnt1_max=0,cnt2_max=1 -> bit=1; both=1 -> bit=0 and tie flag=1; go NEXT.
REQ-025 No decision and timer==TIMEOUT-1 -> bit=0, tie flag=1, go NEXT (race lasts at most TIMEOUT cycles).
REQ-026 NEXT (1 cycle): ro_en=0, cnt_clr_n=1; write bit/tie into index position; advance LFSR one step; index==NUM_BITS-1 -> DONE else index+1, CLEAR.
REQ-027 LFSR step: Fibonacci, shift left, lfsr[0] <= lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
REQ-028 DONE (1 cycle): resp_valid=1, then IDLE; response/tie_flags hold until next accepted start.
REQ-029 Per-bit latency = CLR_CYCLES + race cycles + 1; start-to-resp_valid = sum over bits + 1.
REQ-030 cnt1_max/cnt2_max ignored outside RACE.

Reset
REQ-031 reset=0 asynchronously forces IDLE, sel0=sel1=0, ro_en=0, cnt_clr_n=0, busy=0, resp_valid=0, response=0, tie_flags=0, LFSR=8'h01, timer=0, index=0.
REQ-032 Reset mid-operation aborts without resp_valid; after release block waits in IDLE for new start.
REQ-033 In IDLE after reset release cnt_clr_n=1, ro_en=0.

Verification
REQ-034 NUM_BITS=8, challenge=8'h01, cnt2_max asserted 5 cycles into each race -> bit0 sel0=1,sel1=0; bit1 sel0=2,sel1=0; response=8'hFF, tie_flags=0, one resp_valid pulse.
REQ-035 challenge=8'h00 -> identical sel sequence and result to challenge=8'h01.
REQ-036 LFSR value 8'h33 reached -> sel0=3, sel1=4'hB, never equal.
REQ-037 Both flags asserted same RACE cycle on bit 2 -> response[2]=0, tie_flags[2]=1; no flags with TIMEOUT=16 -> each race exactly 16 cycles, tie_flags=8'hFF.
REQ-038 reset pulsed low during RACE of bit 3 -> all outputs at reset values immediately, no resp_valid; new start runs full sequence correctly.
REQ-039 start held high through a run -> second run begins only after DONE->IDLE; cnt_clr_n low exactly CLR_CYCLES cycles before every race.

Source files
------------

// File: rtl/ro_puf_ctrl.sv
`timescale 1ns/1ps
// Ring-oscillator PUF race controller: walks an LFSR-driven pair of mux selects,
// runs one counter race per response bit and collects the winners and tie flags.
module ro_puf_ctrl #(
    parameter int NUM_BITS   = 8,
    parameter int CLR_CYCLES = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          challenge,
    input  logic                cnt1_max,
    input  logic                cnt2_max,
    output logic [3:0]          sel0,
    output logic [3:0]          sel1,
    output logic                ro_en,
    output logic                cnt_clr_n,
    output logic                busy,
    output logic                resp_valid,
    output logic [NUM_BITS-1:0] response,
    output logic [NUM_BITS-1:0] tie_flags
);

    localparam int IDX_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BITS - 1);
    localparam logic [CLR_W-1:0] LAST_CLR  = CLR_W'(CLR_CYCLES - 1);
    localparam logic [15:0]      LAST_TICK = 16'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RACE  = 3'd2;
    localparam logic [2:0] S_NEXT  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [7:0]          r_lfsr;
    logic [3:0]          r_sel0;
    logic [3:0]          r_sel1;
    logic [15:0]         r_timer;
    logic [CLR_W-1:0]    r_clr_cnt;
    logic [IDX_W-1:0]    r_idx;
    logic                r_bit;
    logic                r_tie;
    logic                r_ro_en;
    logic                r_cnt_clr_n;
    logic                r_busy;
    logic                r_resp_valid;
    logic [NUM_BITS-1:0] r_response;
    logic [NUM_BITS-1:0] r_tie_flags;

    logic [2:0]          w_state_nxt;
    logic [7:0]          w_lfsr_nxt;
    logic                w_bit;
    logic                w_tie;

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    // Oscillator B must never share a mux input with oscillator A.
    function automatic logic [3:0] pick_sel1(input logic [7:0] v);
        return (v[7:4] == v[3:0]) ? (v[7:4] ^ 4'h8) : v[7:4];
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_nxt  = r_lfsr;
        w_bit       = 1'b0;
        w_tie       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_CLEAR;
                    w_lfsr_nxt  = (challenge == 8'h00) ? 8'h01 : challenge;
                end
            end
            S_CLEAR: begin
                if (r_clr_cnt == LAST_CLR) begin
                    w_state_nxt = S_RACE;
                end
            end
            S_RACE: begin
                if (cnt1_max || cnt2_max) begin
                    w_bit       = cnt2_max & ~cnt1_max;
                    w_tie       = cnt1_max & cnt2_max;
                    w_state_nxt = S_NEXT;
                end else if (r_timer == LAST_TICK) begin
                    w_tie       = 1'b1;
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_lfsr_nxt  = lfsr_step(r_lfsr);
                w_state_nxt = (r_idx == LAST_IDX) ? S_DONE : S_CLEAR;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_lfsr       <= 8'h01;
            r_sel0       <= 4'h0;
            r_sel1       <= 4'h0;
            r_timer      <= 16'h0000;
            r_clr_cnt    <= '0;
            r_idx        <= '0;
            r_bit        <= 1'b0;
            r_tie        <= 1'b0;
            r_ro_en      <= 1'b0;
            r_cnt_clr_n  <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
            r_response   <= '0;
            r_tie_flags  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_lfsr       <= w_lfsr_nxt;
            // Outputs are registered from the next state so they line up with r_state.
            r_ro_en      <= (w_state_nxt == S_RACE);
            r_cnt_clr_n  <= (w_state_nxt != S_CLEAR);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_resp_valid <= (w_state_nxt == S_DONE);
            r_clr_cnt    <= (r_state == S_CLEAR) ? r_clr_cnt + CLR_W'(1) : '0;
            r_timer      <= (r_state == S_RACE) ? r_timer + 16'd1 : 16'h0000;

            if ((w_state_nxt == S_CLEAR) && (r_state != S_CLEAR)) begin
                r_sel0 <= w_lfsr_nxt[3:0];
                r_sel1 <= pick_sel1(w_lfsr_nxt);
            end

            if (r_state == S_RACE) begin
                r_bit <= w_bit;
                r_tie <= w_tie;
            end

            if ((r_state == S_IDLE) && start) begin
                r_idx       <= '0;
                r_response  <= '0;
                r_tie_flags <= '0;
            end

            if (r_state == S_NEXT) begin
                r_response[r_idx]  <= r_bit;
                r_tie_flags[r_idx] <= r_tie;
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign sel0       = r_sel0;
    assign sel1       = r_sel1;
    assign ro_en      = r_ro_en;
    assign cnt_clr_n  = r_cnt_clr_n;
    assign busy       = r_busy;
    assign resp_valid = r_resp_valid;
    assign response   = r_response;
    assign tie_flags  = r_tie_flags;

endmodule
